// File: rtl/pipeline_wrapped_nch.sv
// NUM_CH independent pipelines sharing one increment stage through a round-robin arbiter.
// Losing channels stall globally or locally; per-channel flush and a saturating contention counter.
module pipeline_wrapped_nch #(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 32,
    parameter int POST_STAGES = 1,
    parameter int STALL_MODE  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        flush,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH-1:0]        stall,
    output logic [NUM_CH-1:0]        grant,
    output logic [15:0]              conflict_count
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef logic [NUM_CH-1:0][DATA_W-1:0] lane_t;

    function automatic logic [DATA_W-1:0] res_op(input logic [DATA_W-1:0] v);
        return v + DATA_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    lane_t             in_lanes;
    logic [NUM_CH-1:0] vld_p0_q, vld_p0_d;
    lane_t             data_p0_q, data_p0_d;
    logic [NUM_CH-1:0] vld_p1_q, vld_p1_d;
    lane_t             data_p1_q, data_p1_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0] req, grant_w, lose, stall_w;
    logic [PTR_W-1:0]  win_idx;
    logic              found;
    logic              contend;

    assign in_lanes = in_data;

    // Round robin: scan upward from the channel after the last winner, wrapping.
    always_comb begin
        req     = vld_p0_q & ~flush;
        grant_w = '0;
        win_idx = rr_ptr_q;
        found   = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!found && req[c] && (c == (int'(rr_ptr_q) + k) % NUM_CH)) begin
                    found      = 1'b1;
                    grant_w[c] = 1'b1;
                    win_idx    = PTR_W'(c);
                end
            end
        end
        contend = ($countones(req) > 1);
    end

    always_comb begin
        lose = req & ~grant_w;
        if (STALL_MODE == 1) begin
            stall_w = lose;
        end else begin
            stall_w = (|lose) ? '1 : '0;
        end
        stall_w = stall_w & ~flush;
    end

    assign stall = stall_w;
    assign grant = grant_w;

    always_comb begin
        vld_p0_d  = vld_p0_q;
        data_p0_d = data_p0_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (flush[c]) begin
                vld_p0_d[c] = 1'b0;
            end else if (!stall_w[c]) begin
                vld_p0_d[c]  = in_valid[c];
                data_p0_d[c] = in_lanes[c];
            end else if (grant_w[c]) begin
                // Granted but frozen by a global stall: its item moved on, leave a bubble.
                vld_p0_d[c] = 1'b0;
            end
            data_p1_d[c] = res_op(data_p0_q[c]);
        end
        vld_p1_d = grant_w & ~flush;
        rr_ptr_d = found ? win_idx : rr_ptr_q;
        cnt_d    = contend ? sat_inc16(cnt_q) : cnt_q;
    end

    // S0 input registers / S1 resource result / arbiter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0_q  <= '0;
            data_p0_q <= '0;
            vld_p1_q  <= '0;
            data_p1_q <= '0;
            rr_ptr_q  <= PTR_W'(NUM_CH - 1);
            cnt_q     <= '0;
        end else begin
            vld_p0_q  <= vld_p0_d;
            data_p0_q <= data_p0_d;
            vld_p1_q  <= vld_p1_d;
            data_p1_q <= data_p1_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign conflict_count = cnt_q;

    generate
        if (POST_STAGES > 0) begin : g_post
            logic [NUM_CH-1:0] vld_p2_q  [POST_STAGES];
            lane_t             data_p2_q [POST_STAGES];

            // Post-resource shift stages; flush clears the channel's valid everywhere.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < POST_STAGES; s++) begin
                        vld_p2_q[s]  <= '0;
                        data_p2_q[s] <= '0;
                    end
                end else begin
                    vld_p2_q[0]  <= vld_p1_q & ~flush;
                    data_p2_q[0] <= data_p1_q;
                    for (int s = 1; s < POST_STAGES; s++) begin
                        vld_p2_q[s]  <= vld_p2_q[s-1] & ~flush;
                        data_p2_q[s] <= data_p2_q[s-1];
                    end
                end
            end

            assign out_valid = vld_p2_q[POST_STAGES-1];
            assign out_data  = data_p2_q[POST_STAGES-1];
        end else begin : g_nopost
            assign out_valid = vld_p1_q;
            assign out_data  = data_p1_q;
        end
    endgenerate

endmodule

// File: tb/tb_pipeline_wrapped_nch.sv
// Bench for pipeline_wrapped_nch: a global-stall and a local-stall instance driven by shared stimulus,
// checked against a transaction-level scoreboard model plus directed vectors.
module tb_pipeline_wrapped_nch;
    localparam int N = 2;
    localparam int W = 32;
    localparam int P = 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   flush;
    logic [N*W-1:0] od0, od1;
    logic [N-1:0]   ov0, ov1, st0, st1, gr0, gr1;
    logic [15:0]    cc0, cc1;

    always #5 clk = ~clk;

    pipeline_wrapped_nch #(.NUM_CH(N), .DATA_W(W), .POST_STAGES(P), .STALL_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .flush(flush),
        .out_data(od0), .out_valid(ov0), .stall(st0), .grant(gr0), .conflict_count(cc0));

    pipeline_wrapped_nch #(.NUM_CH(N), .DATA_W(W), .POST_STAGES(P), .STALL_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .flush(flush),
        .out_data(od1), .out_valid(ov1), .stall(st1), .grant(gr1), .conflict_count(cc1));

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Reference model: index 0 = global stall, 1 = local stall.
    logic         mv   [2][N];
    logic [W-1:0] md   [2][N];
    logic [N-1:0] mreq [2];
    logic [N-1:0] mg   [2];
    logic [N-1:0] ms   [2];
    int           mptr [2];
    int           mcnt [2];
    int           mwin [2];
    int           mnreq[2];

    typedef struct {
        int           m;
        int           ch;
        logic [W-1:0] d;
        int           due;
    } pend_t;
    pend_t q[$];

    logic [N-1:0] pre_g0, pre_s0, pre_g1, pre_s1;

    typedef struct {
        logic [N-1:0] iv;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [N-1:0] fl;
        logic [N-1:0] eg;
        logic [N-1:0] es;
        logic [N-1:0] eov;
        logic [W-1:0] eod0;
        logic [W-1:0] eod1;
        logic [15:0]  ecc;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < N; c++) begin
                mv[m][c] = 1'b0;
                md[m][c] = '0;
            end
            mptr[m] = N - 1;
            mcnt[m] = 0;
        end
        q.delete();
    endtask

    task automatic model_comb();
        for (int m = 0; m < 2; m++) begin
            int   win;
            int   nreq;
            logic anylose;
            win = -1;
            nreq = 0;
            anylose = 1'b0;
            for (int c = 0; c < N; c++) begin
                mreq[m][c] = mv[m][c] && !flush[c];
                if (mreq[m][c]) nreq++;
            end
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (mptr[m] + k) % N;
                if (win < 0 && mreq[m][idx]) win = idx;
            end
            mg[m] = '0;
            if (win >= 0) mg[m][win] = 1'b1;
            for (int c = 0; c < N; c++)
                if (mreq[m][c] && c != win) anylose = 1'b1;
            for (int c = 0; c < N; c++)
                ms[m][c] = ((m == 1) ? (mreq[m][c] && c != win) : anylose) && !flush[c];
            mwin[m] = win;
            mnreq[m] = nreq;
        end
    endtask

    task automatic model_seq(input int t);
        for (int m = 0; m < 2; m++) begin
            if (mnreq[m] >= 2 && mcnt[m] < 65535) mcnt[m]++;
            if (mwin[m] >= 0) begin
                pend_t e;
                logic [W-1:0] r;
                r = md[m][mwin[m]] + 32'd1;
                e.m = m; e.ch = mwin[m]; e.d = r; e.due = t + P;
                q.push_back(e);
                mptr[m] = mwin[m];
            end
            for (int c = 0; c < N; c++) begin
                if (flush[c]) begin
                    for (int i = q.size() - 1; i >= 0; i--)
                        if (q[i].m == m && q[i].ch == c && q[i].due >= t) q.delete(i);
                    mv[m][c] = 1'b0;
                end else if (!ms[m][c]) begin
                    mv[m][c] = in_valid[c];
                    md[m][c] = in_data[c*W +: W];
                end else if (mg[m][c]) begin
                    mv[m][c] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_outputs(input int t);
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < N; c++) begin
                int           f;
                logic         av;
                logic [W-1:0] ad;
                f = -1;
                foreach (q[i]) if (q[i].m == m && q[i].ch == c && q[i].due == t) f = i;
                av = (m == 0) ? ov0[c] : ov1[c];
                ad = (m == 0) ? od0[c*W +: W] : od1[c*W +: W];
                chk($sformatf("out_valid m%0d ch%0d edge%0d", m, c, t), 64'(av), 64'(f >= 0));
                if (f >= 0) chk($sformatf("out_data m%0d ch%0d edge%0d", m, c, t), 64'(ad), 64'(q[f].d));
            end
        end
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].due <= t) q.delete(i);
        chk("conflict_count m0", 64'(cc0), 64'(mcnt[0]));
        chk("conflict_count m1", 64'(cc1), 64'(mcnt[1]));
    endtask

    // Called one time unit after a rising edge with inputs already driven.
    task automatic do_cycle();
        #2;
        model_comb();
        chk("grant m0", 64'(gr0), 64'(mg[0]));
        chk("stall m0", 64'(st0), 64'(ms[0]));
        chk("grant m1", 64'(gr1), 64'(mg[1]));
        chk("stall m1", 64'(st1), 64'(ms[1]));
        pre_g0 = gr0; pre_s0 = st0; pre_g1 = gr1; pre_s1 = st1;
        @(posedge clk);
        model_seq(edge_no);
        #1;
        check_outputs(edge_no);
        edge_no++;
    endtask

    task automatic reset_pulse();
        in_valid = '0; flush = '0; in_data = '0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        chk("async reset out_valid", 64'({ov1, ov0}), 64'(0));
        chk("async reset out_data m0", 64'(od0), 64'(0));
        chk("async reset out_data m1", 64'(od1), 64'(0));
        chk("async reset counts", 64'({cc1, cc0}), 64'(0));
        chk("async reset grant", 64'({gr1, gr0}), 64'(0));
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic new_inputs(input logic hold_en);
        for (int c = 0; c < N; c++) begin
            logic hold;
            hold = hold_en && (pre_s0[c] || pre_s1[c]) && in_valid[c] && !flush[c];
            if (!hold) begin
                logic [W-1:0] d;
                d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                in_valid[c] = ($urandom_range(0, 3) != 0);
                in_data[c*W +: W] = d;
            end
            flush[c] = ($urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        //          iv     d0            d1            fl     eg     es     eov    eod0         eod1         ecc
        tbl[0] = '{2'b11, 32'h5,        32'hA,        2'b00, 2'b00, 2'b00, 2'b00, 32'h0,       32'h0,       16'd0};
        tbl[1] = '{2'b00, 32'h0,        32'h0,        2'b00, 2'b01, 2'b11, 2'b00, 32'h0,       32'h0,       16'd1};
        tbl[2] = '{2'b00, 32'h0,        32'h0,        2'b00, 2'b10, 2'b00, 2'b01, 32'h6,       32'h0,       16'd1};
        tbl[3] = '{2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 2'b00, 2'b10, 32'h0,       32'hB,       16'd1};
        tbl[4] = '{2'b01, 32'h10,       32'h0,        2'b00, 2'b00, 2'b00, 2'b00, 32'h0,       32'h0,       16'd1};
        tbl[5] = '{2'b00, 32'h0,        32'h0,        2'b00, 2'b01, 2'b00, 2'b00, 32'h0,       32'h0,       16'd1};
        tbl[6] = '{2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 2'b00, 2'b01, 32'h11,      32'h0,       16'd1};
        tbl[7] = '{2'b10, 32'h0,        32'hFFFFFFFF, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,       32'h0,       16'd1};
        tbl[8] = '{2'b00, 32'h0,        32'h0,        2'b00, 2'b10, 2'b00, 2'b00, 32'h0,       32'h0,       16'd1};
        tbl[9] = '{2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 2'b00, 2'b10, 32'h0,       32'h0,       16'd1};

        reset = 1'b1; in_valid = '0; flush = '0; in_data = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset out_valid", 64'({ov1, ov0}), 64'(0));
        chk("reset out_data", 64'(od0), 64'(0));
        chk("reset count", 64'({cc1, cc0}), 64'(0));
        chk("reset stall/grant", 64'({st1, st0, gr1, gr0}), 64'(0));
        reset = 1'b0;

        // Directed vectors against the global-stall instance.
        for (int r = 0; r < 10; r++) begin
            in_valid = tbl[r].iv;
            in_data  = {tbl[r].d1, tbl[r].d0};
            flush    = tbl[r].fl;
            do_cycle();
            chk($sformatf("tbl%0d grant", r), 64'(pre_g0), 64'(tbl[r].eg));
            chk($sformatf("tbl%0d stall", r), 64'(pre_s0), 64'(tbl[r].es));
            chk($sformatf("tbl%0d out_valid", r), 64'(ov0), 64'(tbl[r].eov));
            if (tbl[r].eov[0]) chk($sformatf("tbl%0d out_data ch0", r), 64'(od0[W-1:0]), 64'(tbl[r].eod0));
            if (tbl[r].eov[1]) chk($sformatf("tbl%0d out_data ch1", r), 64'(od0[2*W-1:W]), 64'(tbl[r].eod1));
            chk($sformatf("tbl%0d count", r), 64'(cc0), 64'(tbl[r].ecc));
        end

        // Flush of ch1 while it holds an item in S1 and a contended item in S0.
        reset_pulse();
        in_valid = 2'b10; in_data = {32'hA0, 32'h0};
        do_cycle();
        in_valid = 2'b11; in_data = {32'hB0, 32'h30};
        do_cycle();
        chk("flush seq grant before", 64'(pre_g0), 64'(2'b10));
        in_valid = 2'b10; in_data = {32'hC0, 32'h0}; flush = 2'b10;
        do_cycle();
        chk("flush seq grant", 64'(pre_g0), 64'(2'b01));
        chk("flush seq stall", 64'(pre_s0), 64'(2'b00));
        chk("flush seq out_valid e2", 64'(ov0), 64'(2'b00));
        in_valid = 2'b10; in_data = {32'hD0, 32'h0}; flush = 2'b00;
        do_cycle();
        chk("flush seq accept stall", 64'(pre_s0), 64'(2'b00));
        chk("flush seq ch0 valid", 64'(ov0), 64'(2'b01));
        chk("flush seq ch0 data", 64'(od0[W-1:0]), 64'(32'h31));
        in_valid = 2'b00;
        do_cycle();
        chk("flush seq quiet", 64'(ov0), 64'(2'b00));
        do_cycle();
        chk("flush seq new ch1 valid", 64'(ov0), 64'(2'b10));
        chk("flush seq new ch1 data", 64'(od0[2*W-1:W]), 64'(32'hD1));

        // Randomised traffic with a mid-stream asynchronous reset.
        reset_pulse();
        pre_s0 = '0; pre_s1 = '0;
        new_inputs(1'b0);
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                mid_reset();
                in_valid = 2'b11; flush = 2'b00; in_data = {32'h77, 32'h66};
                do_cycle();
                in_valid = 2'b00;
                do_cycle();
                chk("post-reset first grant m0", 64'(pre_g0), 64'(2'b01));
                chk("post-reset first grant m1", 64'(pre_g1), 64'(2'b01));
            end
            do_cycle();
            new_inputs(1'b1);
        end

        // Persistent contention: round-robin alternation and counter saturation.
        reset_pulse();
        in_valid = 2'b11;
        for (int i = 0; i < 65545; i++) begin
            in_data = {32'($urandom), 32'($urandom)};
            do_cycle();
            if (i >= 1 && i <= 20) begin
                chk($sformatf("rr alternate %0d", i), 64'(pre_g1), 64'((i % 2 == 1) ? 2'b01 : 2'b10));
                chk($sformatf("granted not stalled %0d", i), 64'(pre_s1 & pre_g1), 64'(0));
            end
        end
        chk("count saturates", 64'(cc1), 64'(16'hFFFF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
